// File: rtl/play_time_pkg.sv
// play_time_pkg: shared FSM states, step counts and 7-segment patterns for play_time_display.
package play_time_pkg;
  typedef enum logic [1:0] {IDLE, DIV, BCD, LATCH} state_t;
  localparam int DIV_STEPS = 16;
  localparam int BCD_STEPS = 7;
  localparam int DEF_MAX_SEC = 5999;
  // Active-low g..a patterns, entry 9 first so index == digit.
  localparam logic [9:0][6:0] SEG_LUT = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                         7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  // One double-dabble step on {bcd[7:0], bin[6:0]}: add 3 to nibbles >= 5, then shift.
  function automatic logic [14:0] dabble(input logic [14:0] s);
    logic [14:0] a;
    a = s;
    a[10:7] = (a[10:7] >= 4'd5) ? a[10:7] + 4'd3 : a[10:7];
    a[14:11] = (a[14:11] >= 4'd5) ? a[14:11] + 4'd3 : a[14:11];
    return {a[13:0], 1'b0};
  endfunction
endpackage

// File: rtl/play_time_display_if.sv
// play_time_display_if: seconds input and MM:SS display outputs of play_time_display.
interface play_time_display_if;
  logic [15:0] TIME_SEC;
  logic [15:0] DIGITS;
  logic        BUSY;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  modport master (output TIME_SEC, input DIGITS, BUSY, AN, SEG);
  modport slave  (input TIME_SEC, output DIGITS, BUSY, AN, SEG);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit plus DP flag to active-low segments; non-decimal codes blank.
module seg7_decode
  import play_time_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);
  assign seg = {~dp, (bcd < 4'd10) ? SEG_LUT[bcd] : 7'h7F};
endmodule

// File: rtl/play_time_display.sv
// play_time_display: elapsed seconds to MM:SS via serial divide-by-60 and double-dabble, with digit scan.
module play_time_display
  import play_time_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int MAX_SEC  = DEF_MAX_SEC
) (
  input logic CLK,
  input logic RST,
  play_time_display_if.slave bus
);
  localparam int SW = $clog2(SCAN_DIV);
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   opnd_q, opnd_d, last_q, last_d, digits_q, digits_d;
  logic [6:0]    rem_q, rem_d;
  logic [14:0]   qs_q, qs_d, rs_q, rs_d;
  logic          pend_q, pend_d, busy_q, busy_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d, seg_w;
  logic [7:0]    trial;
  logic          fit, wrap;
  logic [6:0]    rem_n;
  logic [15:0]   opnd_n;
  // Restoring division: operand shifts out MSB-first while quotient bits shift in.
  assign trial  = {rem_q, opnd_q[15]};
  assign fit    = trial >= 8'd60;
  assign rem_n  = fit ? 7'(trial - 8'd60) : trial[6:0];
  assign opnd_n = {opnd_q[14:0], fit};
  assign wrap   = scan_q == SW'(SCAN_DIV - 1);
  seg7_decode u_dec (.bcd(digits_q[idx_q*4 +: 4]), .dp(idx_q == 2'd2), .seg(seg_w));
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    rem_d    = rem_q;
    qs_d     = qs_q;
    rs_d     = rs_q;
    last_d   = last_q;
    pend_d   = pend_q;
    busy_d   = busy_q;
    digits_d = digits_q;
    case (state_q)
      IDLE: if (bus.TIME_SEC != last_q || pend_q) begin
        opnd_d  = (bus.TIME_SEC >= 16'(MAX_SEC)) ? 16'(MAX_SEC) : bus.TIME_SEC;
        rem_d   = '0;
        last_d  = bus.TIME_SEC;
        pend_d  = 1'b0;
        busy_d  = 1'b1;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        opnd_d  = opnd_n;
        rem_d   = rem_n;
        qs_d    = {8'd0, opnd_n[6:0]};
        rs_d    = {8'd0, rem_n};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(DIV_STEPS - 1)) ? BCD : DIV;
      end
      BCD: begin
        qs_d    = dabble(qs_q);
        rs_d    = dabble(rs_q);
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(BCD_STEPS - 1)) ? LATCH : BCD;
      end
      LATCH: begin
        digits_d = {qs_q[14:7], rs_q[14:7]};
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    endcase
    scan_d = wrap ? '0 : scan_q + 1'b1;
    idx_d  = wrap ? idx_q + 2'd1 : idx_q;
    an_d   = ~(4'b0001 << idx_q);
    seg_d  = seg_w;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      qs_q     <= '0;
      rs_q     <= '0;
      last_q   <= '0;
      pend_q   <= 1'b1;
      busy_q   <= 1'b0;
      digits_q <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
      an_q     <= 4'hF;
      seg_q    <= 8'hFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      qs_q     <= qs_d;
      rs_q     <= rs_d;
      last_q   <= last_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      digits_q <= digits_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end
  assign bus.DIGITS = digits_q;
  assign bus.BUSY   = busy_q;
  assign bus.AN     = an_q;
  assign bus.SEG    = seg_q;
endmodule

// File: doc/play_time_display.md
# play_time_display

Consumes the 16-bit elapsed-playback-seconds count produced by the play-time counter and drives the board's 4-digit multiplexed 7-segment display as MM:SS. A sequential divide-by-60 followed by a sequential binary-to-BCD conversion runs only when the seconds value changes. A free-running scan counter refreshes the digits. It sits between the play-time counter and the top-level display pins, on the same 1 MHz system clock.

## Interface
- SCAN_DIV, 1000: CLK cycles each digit stays enabled (1 ms at 1 MHz); legal range ≥ 2.
- MAX_SEC, 5999: saturation point; inputs ≥ MAX_SEC display 99:59.
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- TIME_SEC  input  16  elapsed seconds; updated by the upstream counter on falling edge, so it is stable at every rising edge.
- DIGITS  output  16  BCD register: [15:12] minutes tens, [11:8] minutes ones, [7:4] seconds tens, [3:0] seconds ones.
- BUSY  output  1  high while a conversion is in progress.
- AN  output  4  digit enables, active-low; AN[0] = seconds ones … AN[3] = minutes tens.
- SEG  output  8  active-low segments; SEG[7] = DP, SEG[6:0] = g..a.

## Operation
- FSM states: IDLE, DIV, BCD, LATCH.
- IDLE:
  - If TIME_SEC ≠ last_sec or refresh_pending, capture min(TIME_SEC, MAX_SEC) into the operand.
  - Store the raw TIME_SEC into last_sec.
  - Clear refresh_pending, set BUSY, go to DIV.
- DIV: 16-step restoring division of the operand by 60, one quotient bit per cycle, MSB first. Yields quotient q (≤ 99) and remainder r (≤ 59), 7 bits each.
- BCD: 7-step shift-add-3 (double-dabble) on q and r in parallel, one step per cycle. The add-3 is applied to any nibble ≥ 5 before each shift.
- LATCH:
  - DIGITS ← {q_bcd, r_bcd}, BUSY ← 0, go to IDLE.
  - DIGITS never shows a partial result.
- Changes of TIME_SEC during DIV/BCD/LATCH are ignored. They are picked up at the next IDLE cycle by the last_sec comparison.
- Leading zeros are displayed (e.g. 00:07).
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. On wrap, the 2-bit digit index advances 0→1→2→3→0.
  - AN has the single active-low bit at the index position.
  - SEG decodes the DIGITS nibble for that index. DP (SEG[7]) is 0 only at index 2; all other DP are 1.
  - Scan runs independently of the FSM.
- Nibble values 10–15 cannot occur. Their decode is all segments off (7'h7F).

## Timing
- Reset values: DIGITS=16'h0000, BUSY=0, AN=4'b1111, SEG=8'hFF, scan_cnt=0, digit index=0, FSM=IDLE, last_sec=0, refresh_pending=1.
- RST high overrides everything in the same edge, including mid-conversion. The partial result is discarded and DIGITS returns to 0000.
- First rising edge after RST deasserts: IDLE captures unconditionally, because refresh_pending is set.
- Latency:
  - Capture edge E0, DIV on E1–E16, BCD on E17–E23, LATCH on E24.
  - DIGITS is valid and BUSY=0 after E24.
  - Earliest next capture is E25, so back-to-back changes give one update per 25 cycles.
- AN/SEG:
  - Registered outputs; new index is visible one cycle after the scan_cnt wrap edge.
  - First enabled digit is AN=4'b1110, one cycle after reset deasserts.
- Seconds-to-seconds input changes (10⁶ cycles apart) are far slower than the 25-cycle conversion, so no update is ever lost in normal use.

## Structure
- Package play_time_pkg holds:
  - the FSM state enum;
  - DIV_STEPS=16 and BCD_STEPS=7;
  - the default MAX_SEC;
  - the 10-entry active-low segment pattern constant for digits 0–9.
- One sub-module, seg7_decode: combinational 4-bit BCD plus a DP flag in, 8-bit active-low SEG out. It is instantiated once on the scan-selected nibble.
- The divider, double-dabble, FSM and scan counter stay in the top module.

## Test plan
- Reset: hold RST 3 cycles with TIME_SEC=0, then release.
  - During reset: AN=1111, SEG=FF, DIGITS=0000.
  - After release: BUSY=1 for 24 cycles, then DIGITS=16'h0000.
- TIME_SEC=125 → DIGITS=16'h0205 exactly 24 cycles after the capture edge. TIME_SEC=3599 → 16'h5959.
- Saturation: TIME_SEC=5999, 6000 and 65535 each → DIGITS=16'h9959.
- Mid-conversion change: TIME_SEC=59, then 60 while BUSY.
  - First result 16'h0059 is latched.
  - A second conversion starts at the following edge and ends with 16'h0100.
- Scan with SCAN_DIV=4 and DIGITS=16'h1234:
  - AN steps 1110, 1101, 1011, 0111 every 4 cycles.
  - SEG shows 4, 3, 2, 1.
  - SEG[7]=0 only while AN=1011.
- Reset mid-conversion: assert RST at DIV step 8 with TIME_SEC=754 → DIGITS=0000. After release, a fresh conversion gives 16'h1234.
